pdp8_kl8e: RTL
==============

PDP8_KL8E -- requirements
Module: pdp8_kl8e

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16, meaning the number of clk cycles per serial bit.
REQ-002 The module SHALL have parameter KBD_DEV, default 6'o03, meaning the keyboard device code.
REQ-003 The module SHALL have parameter TTY_DEV, default 6'o04, meaning the printer device code.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port iot, input, 1 bit: the CPU is executing an IOT instruction.
REQ-007 Port mb, input, 12 bits: IOT instruction word; mb[2:0] SHALL be the operation bits.
REQ-008 Port io_select, input, 6 bits: device code, equal to mb[8:3].
REQ-009 Port io_data_in, input, 12 bits: CPU AC; io_data_in[0] SHALL be PDP-8 bit 11.
REQ-010 Port io_data_out, output, 12 bits: value the CPU loads into AC.
REQ-011 Port io_data_avail, output, 1 bit: when high, the CPU SHALL load AC from io_data_out.
REQ-012 Port io_skip, output, 1 bit: request to skip the next instruction.
REQ-013 Port io_interrupt, output, 1 bit: interrupt request, level-sensitive.
REQ-014 Port rxd, input, 1 bit: asynchronous serial keyboard line, idle high.
REQ-015 Port txd, output, 1 bit: serial printer line, idle high.

Function
REQ-016 Device selection: kbd_sel = iot & (io_select==KBD_DEV); tty_sel = iot & (io_select==TTY_DEV).
REQ-017 Side effects (flag, buffer and IE changes) SHALL occur once per IOT, on the first cycle a select is high after being low (registered edge detect).
REQ-018 io_skip, io_data_avail and io_data_out SHALL be combinational and valid while the select is high; otherwise they SHALL be 0.
REQ-019 Keyboard operations: 6030 KCF clears kbd_flag; 6031 KSF skips if kbd_flag; 6032 KCC clears kbd_flag and returns 0 with avail; 6034 KRS returns AC|{4'b0,rx_buf} with avail; 6035 KIE sets ie from AC[0]; 6036 KRB clears kbd_flag and returns {4'b0,rx_buf} with avail.
REQ-020 Printer operations: 6040 TFL sets tty_flag; 6041 TSF skips if tty_flag; 6042 TCF clears tty_flag; 6044 TPC starts transmission of AC[7:0]; 6046 TLS clears tty_flag and starts transmission of AC[7:0].
REQ-021 Operation codes not listed above SHALL have no effect and SHALL drive no outputs.
REQ-022 io_interrupt SHALL equal ie & (kbd_flag | tty_flag).
REQ-023 Transmitter states: IDLE, START, DATA, STOP. Frame is 8N1, LSB first, each bit lasting CLKS_PER_BIT cycles. txd SHALL go low the cycle after the start strobe.
REQ-024 tty_flag SHALL set in the cycle the stop-bit period ends; the transmitter then returns to IDLE.
REQ-025 TPC or TLS while the transmitter is not IDLE SHALL drop the byte and leave the frame in progress untouched. TLS SHALL still clear tty_flag.
REQ-026 Receiver: rxd SHALL pass through a 2-flop synchronizer. A falling edge while IDLE SHALL start a frame. The start bit SHALL be re-checked at mid-bit; if high, the receiver returns to IDLE (glitch).
REQ-027 Receiver sampling: the 8 data bits SHALL be sampled at mid-bit, then the stop bit. If the stop bit is 1, rx_buf is loaded and kbd_flag sets. If the stop bit is 0 (framing error), the byte SHALL be discarded and kbd_flag left unchanged.
REQ-028 Overrun: a new byte arriving with kbd_flag already set SHALL overwrite rx_buf; kbd_flag stays set.
REQ-029 Simultaneous events: if a flag set (rx complete or tx complete) and a clearing IOT occur in the same cycle, the set SHALL win.
REQ-030 The bit counters SHALL be wide enough for CLKS_PER_BIT; no wrap-around SHALL be permitted within a frame.

Reset
REQ-031 While reset is low: txd=1, kbd_flag=0, tty_flag=0, ie=1, rx_buf=0, both FSMs in IDLE, IOT edge-detect register cleared, all outputs except txd at 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; txd SHALL return high asynchronously.

Verification
REQ-033 Scenario TLS: AC=0o0101 -> txd frame start,1,0,0,0,0,0,1,0,stop over 160 cycles; tty_flag=1 and io_interrupt=1 after the frame; TSF -> io_skip=1.
REQ-034 Scenario receive and read: drive 8N1 byte 0x8D on rxd -> kbd_flag=1; KSF skips; KRB -> io_data_out=0o0215 with avail=1; kbd_flag=0 afterwards.
REQ-035 Scenario framing error: byte with stop bit 0 -> kbd_flag remains 0 and rx_buf unchanged; 4-cycle low glitch on rxd -> no frame accepted.
REQ-036 Scenario interrupt enable: KIE with AC=0 then set tty_flag via TFL -> io_interrupt=0; KIE with AC=1 -> io_interrupt=1.
REQ-037 Scenario busy and collision: TPC during an active frame -> byte dropped, txd waveform unchanged; KCF in the same cycle as rx completion -> kbd_flag=1.
REQ-038 Scenario reset: assert reset mid-transmit -> txd=1 immediately, flags=0, ie=1.

Source files
------------

// File: rtl/pdp8_kl8e.sv
// KL8E console teletype: PDP-8 IOT decode for keyboard/printer plus an 8N1 serial transmitter and receiver.
// IOT responses are combinational while selected; side effects land on the first select cycle; a busy printer drops new bytes.
module pdp8_kl8e #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [5:0] KBD_DEV      = 6'o03,
  parameter logic [5:0] TTY_DEV      = 6'o04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [11:0] mb,
  input  logic [5:0]  io_select,
  input  logic [11:0] io_data_in,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_skip,
  output logic        io_interrupt,
  input  logic        rxd,
  output logic        txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT / 2 - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  st_t           tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    rx_buf_q, rx_buf_d;
  logic          txd_q, txd_d;
  logic          kbd_flag_q, kbd_flag_d, tty_flag_q, tty_flag_d, ie_q, ie_d;
  logic          kbd_sel_q, tty_sel_q;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          kbd_sel, tty_sel, kbd_fire, tty_fire;
  logic          tx_start, tx_done, rx_done, rx_fall;
  logic [2:0]    op;
  logic          mb_unused;

  assign mb_unused = ^mb[11:3];
  assign op        = mb[2:0];
  // Qualifying with reset keeps every IOT response at 0 while the block is held in reset.
  assign kbd_sel   = reset & iot & (io_select == KBD_DEV);
  assign tty_sel   = reset & iot & (io_select == TTY_DEV);
  assign kbd_fire  = kbd_sel & ~kbd_sel_q;
  assign tty_fire  = tty_sel & ~tty_sel_q;
  assign rx_fall   = rx_s3_q & ~rx_s2_q;
  assign tx_start  = tty_fire & ((op == 3'o4) | (op == 3'o6)) & (tx_state_q == S_IDLE);

  assign txd          = txd_q;
  assign io_interrupt = ie_q & (kbd_flag_q | tty_flag_q);

  always_comb begin
    io_skip       = 1'b0;
    io_data_avail = 1'b0;
    io_data_out   = '0;
    if (kbd_sel) begin
      case (op)
        3'o1: io_skip = kbd_flag_q;
        3'o2: io_data_avail = 1'b1;
        3'o4: begin
          io_data_avail = 1'b1;
          io_data_out   = io_data_in | {4'b0, rx_buf_q};
        end
        3'o6: begin
          io_data_avail = 1'b1;
          io_data_out   = {4'b0, rx_buf_q};
        end
        default: ;
      endcase
    end
    if (tty_sel && op == 3'o1) io_skip = tty_flag_q;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      S_IDLE: if (tx_start) begin
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_shift_d = io_data_in[7:0];
        txd_d      = 1'b0;
      end
      S_START: if (tx_cnt_q == LAST) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = tx_shift_q[0];
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_DATA: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          txd_d      = tx_shift_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_STOP: if (tx_cnt_q == LAST) begin
        tx_state_d = S_IDLE;
        tx_done    = 1'b1;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      default: tx_state_d = S_IDLE;
    endcase
  end

  // The start bit is qualified at mid-bit, so every later sample also lands at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_fall) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      S_START: if (rx_cnt_q == HALF) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_STOP: if (rx_cnt_q == LAST) begin
        rx_state_d = S_IDLE;
        if (rx_s2_q) begin
          rx_buf_d = rx_shift_q;
          rx_done  = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Flag sets are applied after IOT clears so a same-cycle completion is never lost.
  always_comb begin
    kbd_flag_d = kbd_flag_q;
    tty_flag_d = tty_flag_q;
    ie_d       = ie_q;
    if (kbd_fire) begin
      if (op == 3'o0 || op == 3'o2 || op == 3'o6) kbd_flag_d = 1'b0;
      if (op == 3'o5) ie_d = io_data_in[0];
    end
    if (tty_fire) begin
      if (op == 3'o0) tty_flag_d = 1'b1;
      if (op == 3'o2 || op == 3'o6) tty_flag_d = 1'b0;
    end
    if (rx_done) kbd_flag_d = 1'b1;
    if (tx_done) tty_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      rx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      rx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      txd_q      <= 1'b1;
      kbd_flag_q <= 1'b0;
      tty_flag_q <= 1'b0;
      ie_q       <= 1'b1;
      kbd_sel_q  <= 1'b0;
      tty_sel_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      txd_q      <= txd_d;
      kbd_flag_q <= kbd_flag_d;
      tty_flag_q <= tty_flag_d;
      ie_q       <= ie_d;
      kbd_sel_q  <= kbd_sel;
      tty_sel_q  <= tty_sel;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
    end
  end

endmodule
